cl_axil_initiator: RTL and testbench

Command-driven AXI4-Lite master for the CL: accepts one single-beat read or write command at a time, drives it onto an AXI4-Lite master port, and returns the data and response on a response channel. It is the initiator counterpart of the OCL slave logic. It serves CL-internal agents, such as a sequencer or a debug VIO, that need to reach AXI-Lite register slaves through `axi_register_slice_light`. It has a response-wait timeout, so a hung slave is reported instead of silently stalling the requester.

---
 rtl/cl_axil_initiator_if.sv | 52 +++++
 rtl/cl_axil_initiator.sv | 168 ++++++++++++++++
 tb/tb_cl_axil_initiator.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_axil_initiator_if.sv
// Bundle of command, response and AXI4-Lite master signals for cl_axil_initiator.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface cl_axil_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  logic        m_axi_awvalid;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awready;
  logic        m_axi_wvalid;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wready;
  logic        m_axi_bvalid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bready;
  logic        m_axi_arvalid;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arready;
  logic        m_axi_rvalid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp
  );
endinterface

// File: rtl/cl_axil_initiator.sv
// Single-outstanding AXI4-Lite master driven by a command/response channel pair,
// with a response-wait timeout that reports hung slaves and absorbs their late beat.
module cl_axil_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk_main_a0,
  input  logic                 rst_main,
  cl_axil_initiator_if.master  bus
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP} state_t;

  typedef struct packed {
    logic        orphan;
    logic        aw_done;
    logic        w_done;
    logic [15:0] cnt;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        rready;
  } regs_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  regs_t  r_q, r_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      state_q <= IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    // NOTE: holding every register by default keeps all paths assigned, so no latches infer.
    state_d = state_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (r_q.orphan) begin
          if (bus.m_axi_bvalid || bus.m_axi_rvalid) begin
            r_d.orphan    = 1'b0;
            r_d.bready    = 1'b0;
            r_d.rready    = 1'b0;
            r_d.cmd_ready = 1'b1;
          end
        end else if (bus.cmd_valid && r_q.cmd_ready) begin
          r_d.cmd_ready = 1'b0;
          if (bus.cmd_write) begin
            r_d.awvalid = 1'b1;
            r_d.wvalid  = 1'b1;
            r_d.awaddr  = bus.cmd_addr;
            r_d.wdata   = bus.cmd_wdata;
            r_d.wstrb   = bus.cmd_wstrb;
            r_d.aw_done = 1'b0;
            r_d.w_done  = 1'b0;
            state_d     = WR_REQ;
          end else begin
            r_d.arvalid = 1'b1;
            r_d.araddr  = bus.cmd_addr;
            state_d     = RD_REQ;
          end
        end else begin
          r_d.cmd_ready = 1'b1;
        end
      end
      WR_REQ: begin
        if (r_q.awvalid && bus.m_axi_awready) begin
          r_d.awvalid = 1'b0;
          r_d.aw_done = 1'b1;
        end
        if (r_q.wvalid && bus.m_axi_wready) begin
          r_d.wvalid = 1'b0;
          r_d.w_done = 1'b1;
        end
        if (r_d.aw_done && r_d.w_done) begin
          r_d.bready = 1'b1;
          r_d.cnt    = '0;
          state_d    = WR_RSP;
        end
      end
      RD_REQ: begin
        if (r_q.arvalid && bus.m_axi_arready) begin
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
          r_d.cnt     = '0;
          state_d     = RD_RSP;
        end
      end
      WR_RSP, RD_RSP: begin
        // A beat landing on the expiry cycle wins over the timeout.
        if (state_q == WR_RSP && bus.m_axi_bvalid) begin
          r_d.bready      = 1'b0;
          r_d.rsp_valid   = 1'b1;
          r_d.rsp_resp    = bus.m_axi_bresp;
          r_d.rsp_rdata   = '0;
          r_d.rsp_timeout = 1'b0;
          state_d         = RSP;
        end else if (state_q == RD_RSP && bus.m_axi_rvalid) begin
          r_d.rready      = 1'b0;
          r_d.rsp_valid   = 1'b1;
          r_d.rsp_resp    = bus.m_axi_rresp;
          r_d.rsp_rdata   = bus.m_axi_rdata;
          r_d.rsp_timeout = 1'b0;
          state_d         = RSP;
        end else if (TIMEOUT_EN && r_q.cnt == CNT_LAST) begin
          // Keep both ready lines up so the slave's eventual beat is swallowed.
          r_d.orphan      = 1'b1;
          r_d.bready      = 1'b1;
          r_d.rready      = 1'b1;
          r_d.rsp_valid   = 1'b1;
          r_d.rsp_resp    = 2'b10;
          r_d.rsp_rdata   = 32'hFFFF_FFFF;
          r_d.rsp_timeout = 1'b1;
          state_d         = RSP;
        end else begin
          r_d.cnt = r_q.cnt + 16'd1;
        end
      end
      RSP: begin
        if (r_q.orphan && (bus.m_axi_bvalid || bus.m_axi_rvalid)) begin
          r_d.orphan = 1'b0;
          r_d.bready = 1'b0;
          r_d.rready = 1'b0;
        end
        if (bus.rsp_ready) begin
          r_d.rsp_valid = 1'b0;
          r_d.cmd_ready = ~r_d.orphan;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready     = r_q.cmd_ready;
  assign bus.rsp_valid     = r_q.rsp_valid;
  assign bus.rsp_rdata     = r_q.rsp_rdata;
  assign bus.rsp_resp      = r_q.rsp_resp;
  assign bus.rsp_timeout   = r_q.rsp_timeout;
  assign bus.m_axi_awvalid = r_q.awvalid;
  assign bus.m_axi_awaddr  = r_q.awaddr;
  assign bus.m_axi_wvalid  = r_q.wvalid;
  assign bus.m_axi_wdata   = r_q.wdata;
  assign bus.m_axi_wstrb   = r_q.wstrb;
  assign bus.m_axi_bready  = r_q.bready;
  assign bus.m_axi_arvalid = r_q.arvalid;
  assign bus.m_axi_araddr  = r_q.araddr;
  assign bus.m_axi_rready  = r_q.rready;

endmodule

// File: tb/tb_cl_axil_initiator.sv
// Directed bench for cl_axil_initiator: the bench plays the AXI slave and the requester,
// with expected values worked out by hand for each cycle.
module tb_cl_axil_initiator;

  logic clk_main_a0 = 1'b0;
  logic rst_main;
  int   tests;
  int   fails;

  cl_axil_initiator_if bus();

  cl_axil_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main    (rst_main),
    .bus         (bus)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = wstrb;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_main = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_wstrb = '0;   bus.rsp_ready = 1'b0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid = 1'b0;  bus.m_axi_bresp = 2'b00;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata = '0;     bus.m_axi_rresp = 2'b00;

    // Reset values
    tick(); tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_awvalid", 32'(bus.m_axi_awvalid), 0);
    check("rst_wvalid", 32'(bus.m_axi_wvalid), 0);
    check("rst_arvalid", 32'(bus.m_axi_arvalid), 0);
    check("rst_bready", 32'(bus.m_axi_bready), 0);
    check("rst_rready", 32'(bus.m_axi_rready), 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_resp", 32'(bus.rsp_resp), 0);
    check("rst_rsp_timeout", 32'(bus.rsp_timeout), 0);
    check("rst_awaddr", bus.m_axi_awaddr, 0);
    rst_main = 1'b0;
    tick();
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);

    // Write, zero-wait slave
    bus.rsp_ready = 1'b1; bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    send_cmd(1'b1, 32'h0000_0500, 32'hA5A5_1234, 4'hF);
    check("wr_awvalid", 32'(bus.m_axi_awvalid), 1);
    check("wr_wvalid", 32'(bus.m_axi_wvalid), 1);
    check("wr_awaddr", bus.m_axi_awaddr, 32'h0000_0500);
    check("wr_wdata", bus.m_axi_wdata, 32'hA5A5_1234);
    check("wr_wstrb", 32'(bus.m_axi_wstrb), 32'hF);
    check("wr_cmd_ready_low", 32'(bus.cmd_ready), 0);
    tick();
    check("wr_bready", 32'(bus.m_axi_bready), 1);
    check("wr_awvalid_drop", 32'(bus.m_axi_awvalid), 0);
    check("wr_wvalid_drop", 32'(bus.m_axi_wvalid), 0);
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b00;
    tick();
    bus.m_axi_bvalid = 1'b0;
    check("wr_rsp_valid", 32'(bus.rsp_valid), 1);
    check("wr_rsp_resp", 32'(bus.rsp_resp), 0);
    check("wr_rsp_rdata", bus.rsp_rdata, 0);
    check("wr_rsp_timeout", 32'(bus.rsp_timeout), 0);
    check("wr_bready_drop", 32'(bus.m_axi_bready), 0);
    tick();
    check("wr_rsp_valid_fall", 32'(bus.rsp_valid), 0);
    check("wr_cmd_ready_rise", 32'(bus.cmd_ready), 1);

    // Read with skewed slave
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    send_cmd(1'b0, 32'h0000_0A00, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      check("rd_arvalid_hold", 32'(bus.m_axi_arvalid), 1);
      check("rd_araddr_hold", bus.m_axi_araddr, 32'h0000_0A00);
      tick();
    end
    check("rd_arvalid_hold", 32'(bus.m_axi_arvalid), 1);
    bus.m_axi_arready = 1'b1;
    tick();
    bus.m_axi_arready = 1'b0;
    check("rd_arvalid_drop", 32'(bus.m_axi_arvalid), 0);
    check("rd_rready", 32'(bus.m_axi_rready), 1);
    tick(); tick();
    check("rd_no_rsp_yet", 32'(bus.rsp_valid), 0);
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'hCAFE_F00D; bus.m_axi_rresp = 2'b00;
    tick();
    bus.m_axi_rvalid = 1'b0;
    check("rd_rsp_valid", 32'(bus.rsp_valid), 1);
    check("rd_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    check("rd_rsp_resp", 32'(bus.rsp_resp), 0);
    check("rd_rready_drop", 32'(bus.m_axi_rready), 0);
    tick();
    check("rd_cmd_ready", 32'(bus.cmd_ready), 1);

    // Write channel skew: W completes four cycles before AW
    bus.m_axi_wready = 1'b1;
    send_cmd(1'b1, 32'h0000_0010, 32'h1122_3344, 4'h3);
    tick();
    bus.m_axi_wready = 1'b0;
    check("skew_wvalid_drop", 32'(bus.m_axi_wvalid), 0);
    check("skew_awvalid_hold", 32'(bus.m_axi_awvalid), 1);
    check("skew_bready_low", 32'(bus.m_axi_bready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("skew_awvalid_wait", 32'(bus.m_axi_awvalid), 1);
      check("skew_bready_wait", 32'(bus.m_axi_bready), 0);
    end
    bus.m_axi_awready = 1'b1;
    tick();
    bus.m_axi_awready = 1'b0;
    check("skew_awvalid_drop", 32'(bus.m_axi_awvalid), 0);
    check("skew_bready_rise", 32'(bus.m_axi_bready), 1);
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b00;
    tick();
    bus.m_axi_bvalid = 1'b0;
    check("skew_rsp_valid", 32'(bus.rsp_valid), 1);
    tick();
    check("skew_cmd_ready", 32'(bus.cmd_ready), 1);

    // Back-pressure and SLVERR passthrough
    bus.rsp_ready = 1'b0; bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    send_cmd(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
    tick();
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b10;
    tick();
    bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check("bp_rsp_resp", 32'(bus.rsp_resp), 32'h2);
      check("bp_rsp_rdata", bus.rsp_rdata, 0);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    check("bp_cmd_ready_at_hs", 32'(bus.cmd_ready), 0);
    tick();
    check("bp_rsp_valid_fall", 32'(bus.rsp_valid), 0);
    check("bp_cmd_ready_rise", 32'(bus.cmd_ready), 1);

    // Timeout with late rvalid absorbed
    bus.rsp_ready = 1'b0; bus.m_axi_arready = 1'b1;
    send_cmd(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    tick();
    bus.m_axi_arready = 1'b0;
    check("to_rready", 32'(bus.m_axi_rready), 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_wait", 32'(bus.rsp_valid), 0);
    end
    tick();
    check("to_rsp_valid", 32'(bus.rsp_valid), 1);
    check("to_rsp_resp", 32'(bus.rsp_resp), 32'h2);
    check("to_rsp_rdata", bus.rsp_rdata, 32'hFFFF_FFFF);
    check("to_rsp_timeout", 32'(bus.rsp_timeout), 1);
    check("to_rready_hold", 32'(bus.m_axi_rready), 1);
    check("to_bready_hold", 32'(bus.m_axi_bready), 1);
    bus.rsp_ready = 1'b1;
    tick();
    check("to_rsp_valid_fall", 32'(bus.rsp_valid), 0);
    check("to_orphan_cmd_ready", 32'(bus.cmd_ready), 0);
    tick();
    check("to_orphan_cmd_ready2", 32'(bus.cmd_ready), 0);
    check("to_orphan_rready", 32'(bus.m_axi_rready), 1);
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h1234_5678;
    tick();
    bus.m_axi_rvalid = 1'b0;
    check("to_absorb_rready", 32'(bus.m_axi_rready), 0);
    check("to_absorb_cmd_ready", 32'(bus.cmd_ready), 1);
    check("to_absorb_no_rsp", 32'(bus.rsp_valid), 0);

    // Beat on the expiry cycle wins
    bus.m_axi_arready = 1'b1;
    send_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    tick();
    bus.m_axi_arready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("race_wait", 32'(bus.rsp_valid), 0);
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h0BAD_CAFE; bus.m_axi_rresp = 2'b00;
    tick();
    bus.m_axi_rvalid = 1'b0;
    check("race_rsp_valid", 32'(bus.rsp_valid), 1);
    check("race_rsp_timeout", 32'(bus.rsp_timeout), 0);
    check("race_rsp_rdata", bus.rsp_rdata, 32'h0BAD_CAFE);
    check("race_rsp_resp", 32'(bus.rsp_resp), 0);
    check("race_rready", 32'(bus.m_axi_rready), 0);
    tick();
    check("race_cmd_ready", 32'(bus.cmd_ready), 1);

    // Async reset mid-write
    send_cmd(1'b1, 32'h0000_0050, 32'h7777_7777, 4'hF);
    check("ar_awvalid_before", 32'(bus.m_axi_awvalid), 1);
    #2 rst_main = 1'b1;
    #1;
    check("ar_awvalid_async", 32'(bus.m_axi_awvalid), 0);
    check("ar_wvalid_async", 32'(bus.m_axi_wvalid), 0);
    check("ar_cmd_ready_async", 32'(bus.cmd_ready), 0);
    #1 rst_main = 1'b0;
    tick();
    check("ar_cmd_ready_post", 32'(bus.cmd_ready), 1);
    check("ar_no_rsp", 32'(bus.rsp_valid), 0);
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    send_cmd(1'b1, 32'h0000_0060, 32'h5A5A_5A5A, 4'hF);
    check("ar_new_awaddr", bus.m_axi_awaddr, 32'h0000_0060);
    tick();
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b00;
    tick();
    bus.m_axi_bvalid = 1'b0;
    check("ar_new_rsp_valid", 32'(bus.rsp_valid), 1);
    check("ar_new_rsp_resp", 32'(bus.rsp_resp), 0);
    tick();
    check("ar_new_cmd_ready", 32'(bus.cmd_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
